spi_flash_master: RTL and testbench

- J1 IO-bus peripheral that sequences the SPI configuration flash (SCK/MOSI/MISO/CS) in hardware.
- Replaces bit-banging of the flash pins through the misc.out register.
- Firmware writes one byte and the block shifts it out in SPI mode 0 while capturing the returned byte.
- Sits beside the UART on the one-hot io_addr bus, using the free address bits 7 (data) and 11 (control/status).

---
 rtl/spi_flash_pkg.sv | 35 +++
 rtl/spi_flash_master_timer.sv | 31 +++
 rtl/spi_flash_master.sv | 139 +++++++++++++
 tb/tb_spi_flash_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI configuration-flash master: FSM states,
// status register bit positions and the default IO address map.
//
// IO address map (one-hot io_addr):
//   bit DEF_DATA_BIT (7)  : data register   -> write starts a byte transfer,
//                                              read returns {8'd0, rx_byte}
//   bit DEF_CTRL_BIT (11) : control/status  -> write bit0 sets chip select,
//                                              read returns {13'd0, ovr, cs, busy}
package spi_flash_pkg;

    // LO/HI are the two SCK half-periods of one bit.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10
    } state_t;

    localparam int STAT_BUSY = 0;
    localparam int STAT_CS   = 1;
    localparam int STAT_OVR  = 2;

    localparam int DEF_DATA_BIT = 7;
    localparam int DEF_CTRL_BIT = 11;

    // Status word as seen on io_din when the control register is selected.
    function automatic logic [15:0] status_word(input logic ovr, input logic cs, input logic busy);
        logic [15:0] w;
        w            = '0;
        w[STAT_BUSY] = busy;
        w[STAT_CS]   = cs;
        w[STAT_OVR]  = ovr;
        return w;
    endfunction

endpackage

// File: rtl/spi_flash_master_timer.sv
// SCK half-period timer. Counts clk cycles inside one SCK phase and pulses
// tick on the last cycle of the phase; the counter reloads to zero on every
// tick so each phase is exactly DIV cycles long.
module spi_phase_timer #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic resetq,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(DIV) + 1;

    logic [CW-1:0] cnt;

    // restart holds the counter at zero so the first phase after it is full length.
    assign tick = !restart && (cnt == CW'(DIV - 1));

    // Phase counter: reload on restart or phase end, otherwise count up.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_flash_master.sv
// J1 IO-bus SPI master for the configuration flash (SPI mode 0, MSB first).
// A data write shifts one byte out on MOSI while capturing one byte from MISO;
// chip select is a plain firmware-controlled bit so multi-byte commands can
// be framed across several data writes.
module spi_flash_master
    import spi_flash_pkg::*;
#(
    parameter int DIV      = 2,
    parameter int DATA_BIT = DEF_DATA_BIT,
    parameter int CTRL_BIT = DEF_CTRL_BIT
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic        flash_cs_n
);

    state_t      state, state_nxt;
    logic        tick;
    logic        busy;
    logic        idle;
    logic        wr_data, wr_ctrl;
    logic        cs;
    logic        overrun;
    logic [7:0]  tx_shift;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_byte;
    logic [2:0]  bit_cnt;
    logic        sck_q;
    logic        mosi_q;

    // Reads carry no side effects; only the two select bits and the low data
    // byte are decoded, the rest of the bus is intentionally ignored.
    logic unused_ok;
    assign unused_ok = ^{io_rd, io_addr, io_dout};

    assign wr_data = io_wr & io_addr[DATA_BIT];
    assign wr_ctrl = io_wr & io_addr[CTRL_BIT];
    assign idle    = (state == IDLE);

    spi_phase_timer #(.DIV(DIV)) u_timer (
        .clk     (clk),
        .resetq  (resetq),
        .restart (idle),
        .tick    (tick)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) state <= IDLE;
        else         state <= state_nxt;
    end

    // FSM next state: a data write while idle starts a byte, each tick ends a phase.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_data) state_nxt = LO;
            LO:      if (tick)    state_nxt = HI;
            HI:      if (tick)    state_nxt = (bit_cnt == 3'd7) ? IDLE : LO;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy for the whole byte; CS is purely firmware driven.
    always_comb begin
        busy       = (state != IDLE);
        flash_cs_n = ~cs;
        flash_sck  = sck_q;
        flash_mosi = mosi_q;
    end

    // Register-file writes, shift registers and the registered SCK/MOSI pins.
    // SCK is registered from the next state so the pin never glitches on
    // state decode; MOSI is only updated at transfer start and on SCK falls.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            cs       <= 1'b0;
            overrun  <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            bit_cnt  <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
        end else begin
            sck_q <= (state_nxt == HI);

            if (wr_ctrl) begin
                if (idle) begin
                    cs      <= io_dout[0];
                    overrun <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end

            if (wr_data) begin
                if (idle) begin
                    tx_shift <= io_dout[7:0];
                    bit_cnt  <= '0;
                    mosi_q   <= io_dout[7];
                end else begin
                    overrun  <= 1'b1;
                end
            end

            // MISO is captured on the same clk edge that raises SCK.
            if (state == LO && tick) begin
                rx_shift <= {rx_shift[6:0], flash_miso};
            end

            if (state == HI && tick) begin
                if (bit_cnt == 3'd7) begin
                    rx_byte <= rx_shift;
                end else begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                    bit_cnt  <= bit_cnt + 3'd1;
                    mosi_q   <= tx_shift[6];
                end
            end
        end
    end

    // Read mux; zero when not selected so it can be ORed into the IO bus.
    always_comb begin
        io_din = '0;
        if (io_addr[DATA_BIT]) io_din = io_din | {8'd0, rx_byte};
        if (io_addr[CTRL_BIT]) io_din = io_din | status_word(overrun, cs, busy);
    end

endmodule

// File: tb/tb_spi_flash_master.sv
// Bench for spi_flash_master: three instances (DIV=2, 1, 5) share the IO bus,
// each with a flash slave model that shifts a byte out on MISO and records MOSI.
`timescale 1ns/1ps
module tb_spi_flash_master;

    localparam logic [15:0] A_DATA = 16'h0080;
    localparam logic [15:0] A_CTRL = 16'h0800;

    logic              clk = 1'b0;
    logic              resetq;
    logic              io_wr, io_rd;
    logic [15:0]       io_addr, io_dout;
    int                sel;
    logic [2:0]        wr, sck, mosi, miso, cs_n;
    logic [2:0][15:0]  din;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic int div_of(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    function automatic logic pick(input logic [7:0] b, input int i);
        logic [2:0] k;
        if (i < 0 || i > 7) return 1'b0;
        k = i[2:0];
        return b[k];
    endfunction

    // Flash slave model state
    int          falls[3]   = '{default: 0};
    int          rises[3]   = '{default: 0};
    int          fbase[3]   = '{default: 0};
    int          rbase[3]   = '{default: 0};
    logic [7:0]  sbyte[3]   = '{default: 8'h00};
    logic [7:0]  mcap[3]    = '{default: 8'h00};
    time         last_r[3]  = '{default: 0};
    time         period[3]  = '{default: 0};

    for (genvar g = 0; g < 3; g++) begin : g_slv
        assign wr[g]   = io_wr && (sel == g);
        // MISO presents the next bit MSB-first, advancing on each SCK fall.
        assign miso[g] = pick(sbyte[g], 7 - (falls[g] - fbase[g]));
        always @(negedge sck[g]) falls[g] = falls[g] + 1;
        always @(posedge sck[g]) begin
            if (rises[g] > 0) period[g] = $time - last_r[g];
            last_r[g] = $time;
            rises[g]  = rises[g] + 1;
            mcap[g]   = {mcap[g][6:0], mosi[g]};
        end
    end

    spi_flash_master #(.DIV(2)) u_div2 (
        .clk(clk), .resetq(resetq), .io_wr(wr[0]), .io_rd(io_rd), .io_addr(io_addr),
        .io_dout(io_dout), .io_din(din[0]), .flash_sck(sck[0]), .flash_mosi(mosi[0]),
        .flash_miso(miso[0]), .flash_cs_n(cs_n[0]));

    spi_flash_master #(.DIV(1)) u_div1 (
        .clk(clk), .resetq(resetq), .io_wr(wr[1]), .io_rd(io_rd), .io_addr(io_addr),
        .io_dout(io_dout), .io_din(din[1]), .flash_sck(sck[1]), .flash_mosi(mosi[1]),
        .flash_miso(miso[1]), .flash_cs_n(cs_n[1]));

    spi_flash_master #(.DIV(5)) u_div5 (
        .clk(clk), .resetq(resetq), .io_wr(wr[2]), .io_rd(io_rd), .io_addr(io_addr),
        .io_dout(io_dout), .io_din(din[2]), .flash_sck(sck[2]), .flash_mosi(mosi[2]),
        .flash_miso(miso[2]), .flash_cs_n(cs_n[2]));

    task automatic wr_io(input int g, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        sel = g; io_addr = a; io_dout = d; io_wr = 1'b1;
        @(negedge clk);
        io_wr = 1'b0; io_addr = A_CTRL;
        #1;
    endtask

    // Counts negedges on which the selected instance reports busy; bounded.
    task automatic wait_idle(output int len);
        len = 0;
        io_addr = A_CTRL;
        #1;
        while (din[sel][0] === 1'b1 && len < 2000) begin
            len++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic arm_slave(input int g, input logic [7:0] b);
        sbyte[g] = b;
        fbase[g] = falls[g];
        rbase[g] = rises[g];
    endtask

    task automatic test_reset();
        resetq = 1'b0; io_wr = 1'b0; io_rd = 1'b0; io_addr = 16'h0000; io_dout = 16'h0000; sel = 0;
        #12;
        for (int g = 0; g < 3; g++) begin
            tests++;
            if ({cs_n[g], sck[g], mosi[g]} !== 3'b100)
                $display("FAIL reset_pins[%0d]: got %b exp 100", g, {cs_n[g], sck[g], mosi[g]});
            if ({cs_n[g], sck[g], mosi[g]} !== 3'b100) fails++;
        end
        io_addr = A_DATA | A_CTRL;
        #1;
        for (int g = 0; g < 3; g++) begin
            tests++;
            if (din[g] !== 16'h0000) begin
                fails++;
                $display("FAIL reset_regs[%0d]: got %h exp 0000", g, din[g]);
            end
        end
        @(negedge clk);
        resetq = 1'b1;
    endtask

    task automatic test_basic();
        int len;
        logic [7:0] tx, rx, prev;
        wr_io(0, A_CTRL, 16'h0001);
        tests++;
        if (cs_n[0] !== 1'b0) begin fails++; $display("FAIL basic_cs: got %b exp 0", cs_n[0]); end
        arm_slave(0, 8'h3C);
        wr_io(0, A_DATA, 16'h00A5);
        wait_idle(len);
        tests++;
        if (len != 32) begin fails++; $display("FAIL basic_busy_len: got %0d exp 32", len); end
        tests++;
        if (mcap[0] !== 8'hA5) begin fails++; $display("FAIL basic_mosi: got %h exp a5", mcap[0]); end
        tests++;
        if (rises[0] - rbase[0] != 8) begin fails++; $display("FAIL basic_sck_rises: got %0d exp 8", rises[0] - rbase[0]); end
        tests++;
        if (period[0] != 40) begin fails++; $display("FAIL basic_sck_period: got %0t exp 40", period[0]); end
        io_addr = A_DATA; #1;
        tests++;
        if (din[0] !== 16'h003C) begin fails++; $display("FAIL basic_rx: got %h exp 003c", din[0]); end
        io_addr = A_CTRL; #1;
        tests++;
        if (din[0] !== 16'h0002) begin fails++; $display("FAIL basic_status: got %h exp 0002", din[0]); end
        // Randomised bytes; mid-transfer reads must still show the previous byte.
        prev = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            tx = 8'($urandom); rx = 8'($urandom);
            arm_slave(0, rx);
            wr_io(0, A_DATA, {8'h00, tx});
            repeat (3) @(negedge clk);
            io_addr = A_DATA; #1;
            tests++;
            if (din[0] !== {8'h00, prev}) begin fails++; $display("FAIL rand_rx_busy[%0d]: got %h exp %h", i, din[0], prev); end
            wait_idle(len);
            tests++;
            if (mcap[0] !== tx) begin fails++; $display("FAIL rand_mosi[%0d]: got %h exp %h", i, mcap[0], tx); end
            io_addr = A_DATA; #1;
            tests++;
            if (din[0] !== {8'h00, rx}) begin fails++; $display("FAIL rand_rx[%0d]: got %h exp %h", i, din[0], rx); end
            prev = rx;
        end
    endtask

    task automatic test_overrun();
        int len;
        logic [7:0] rx;
        rx = 8'($urandom);
        arm_slave(0, rx);
        wr_io(0, A_DATA, 16'h0011);
        repeat (3) @(negedge clk);
        wr_io(0, A_DATA, 16'h0022);
        tests++;
        if (din[0] !== 16'h0007) begin fails++; $display("FAIL ovr_status_busy: got %h exp 0007", din[0]); end
        wait_idle(len);
        tests++;
        if (mcap[0] !== 8'h11) begin fails++; $display("FAIL ovr_shifted: got %h exp 11", mcap[0]); end
        tests++;
        if (din[0] !== 16'h0006) begin fails++; $display("FAIL ovr_status_done: got %h exp 0006", din[0]); end
        io_addr = A_DATA; #1;
        tests++;
        if (din[0] !== {8'h00, rx}) begin fails++; $display("FAIL ovr_rx: got %h exp %h", din[0], rx); end
        wr_io(0, A_CTRL, 16'h0000);
        tests++;
        if (din[0] !== 16'h0000) begin fails++; $display("FAIL ovr_clear: got %h exp 0000", din[0]); end
        tests++;
        if (cs_n[0] !== 1'b1) begin fails++; $display("FAIL ovr_cs_n: got %b exp 1", cs_n[0]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] tx;
        tx = 8'($urandom) | 8'h80;
        wr_io(0, A_CTRL, 16'h0001);
        arm_slave(0, 8'($urandom_range(1, 255)));
        wr_io(0, A_DATA, {8'h00, tx});
        repeat (9) @(negedge clk);
        #2;
        resetq = 1'b0;
        #1;
        tests++;
        if ({cs_n[0], sck[0], mosi[0]} !== 3'b100) begin
            fails++; $display("FAIL mid_reset_pins: got %b exp 100", {cs_n[0], sck[0], mosi[0]});
        end
        io_addr = A_DATA | A_CTRL; #1;
        tests++;
        if (din[0] !== 16'h0000) begin fails++; $display("FAIL mid_reset_regs: got %h exp 0000", din[0]); end
        @(negedge clk);
        resetq = 1'b1;
    endtask

    task automatic test_decode();
        int len;
        logic [7:0] rb;
        logic [15:0] addrs[5];
        logic [15:0] exps[5];
        rb = 8'($urandom_range(1, 255));
        wr_io(0, A_CTRL, 16'h0001);
        arm_slave(0, rb);
        wr_io(0, A_DATA, 16'($urandom));
        wait_idle(len);
        addrs = '{16'h0080, 16'h0800, 16'h1000, 16'h0000, 16'h0880};
        exps  = '{{8'h00, rb}, 16'h0002, 16'h0000, 16'h0000, {8'h00, rb} | 16'h0002};
        wr_io(0, 16'h1000, 16'hFFFF);
        repeat (2) @(negedge clk);
        tests++;
        if ({cs_n[0], sck[0]} !== 2'b00) begin fails++; $display("FAIL decode_pins: got %b exp 00", {cs_n[0], sck[0]}); end
        for (int i = 0; i < 5; i++) begin
            io_addr = addrs[i]; #1;
            tests++;
            if (din[0] !== exps[i]) begin
                fails++; $display("FAIL decode_read[%h]: got %h exp %h", addrs[i], din[0], exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back(input int g);
        int len1, len2, d;
        logic [7:0] b1, s1, b2, s2;
        d = div_of(g);
        b1 = 8'($urandom); s1 = 8'($urandom); b2 = 8'($urandom); s2 = 8'($urandom);
        wr_io(g, A_CTRL, 16'h0001);
        arm_slave(g, s1);
        wr_io(g, A_DATA, {8'h00, b1});
        wait_idle(len1);
        // First idle cycle: read the finished byte and issue the next write.
        io_addr = A_DATA; #1;
        tests++;
        if (din[g] !== {8'h00, s1}) begin fails++; $display("FAIL b2b_rx1[div%0d]: got %h exp %h", d, din[g], s1); end
        tests++;
        if (mcap[g] !== b1) begin fails++; $display("FAIL b2b_mosi1[div%0d]: got %h exp %h", d, mcap[g], b1); end
        arm_slave(g, s2);
        io_dout = {8'h00, b2}; io_wr = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
        wait_idle(len2);
        tests++;
        if (len1 != 16 * d) begin fails++; $display("FAIL b2b_len1[div%0d]: got %0d exp %0d", d, len1, 16 * d); end
        tests++;
        if (len2 != 16 * d) begin fails++; $display("FAIL b2b_len2[div%0d]: got %0d exp %0d", d, len2, 16 * d); end
        tests++;
        if (mcap[g] !== b2) begin fails++; $display("FAIL b2b_mosi2[div%0d]: got %h exp %h", d, mcap[g], b2); end
        tests++;
        if (period[g] != time'(20 * d)) begin fails++; $display("FAIL b2b_period[div%0d]: got %0t exp %0d", d, period[g], 20 * d); end
        tests++;
        if (din[g] !== 16'h0002) begin fails++; $display("FAIL b2b_status[div%0d]: got %h exp 0002", d, din[g]); end
        io_addr = A_DATA; #1;
        tests++;
        if (din[g] !== {8'h00, s2}) begin fails++; $display("FAIL b2b_rx2[div%0d]: got %h exp %h", d, din[g], s2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_reset_mid();
        test_decode();
        test_back_to_back(1);
        test_back_to_back(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
